sysid_check_ctrl: RTL and testbench

Avalon-MM read master that sequences the system-ID slave after reset and on demand. It reads the ID word at address 0 and the timestamp word at address 1, then latches both values and compares them against build-time expected values. It publishes done/match/error status to the painter control logic. It is the only master on the sysid control slave; there is no arbitration.

---
 rtl/sysid_ctrl_pkg.sv | 20 ++
 rtl/sysid_ctrl_timer.sv | 28 ++
 rtl/sysid_check_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID check controller.
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WT_ID,
    ST_RD_TS,
    ST_WT_TS,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int TMR_W   = 16;
  localparam int RETRY_W = 3;

endpackage

// File: rtl/sysid_ctrl_timer.sv
// Per-access stall counter: counts cycles while enabled, saturates at all-ones,
// flags expiry once the count reaches the loaded limit.
module sysid_ctrl_timer
  import sysid_ctrl_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [TMR_W-1:0] i_limit,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count >= i_limit);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master: reads sysid ID and timestamp words after reset or on
// start, then compares them against build-time values.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | after reset; auto-starts the first check
// RD_ID    | read strobe on address 0, stall/timeout counting
// WT_ID    | ID read accepted, waiting out the read latency
// RD_TS    | read strobe on address 1, stall/timeout counting
// WT_TS    | timestamp read accepted, waiting out the read latency
// CHECK    | compare captured words against expected values
// DONE     | status valid; start re-runs the sequence
module sysid_check_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1453786952,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        error
);

  localparam logic [1:0]         LAT_LOAD  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [TMR_W-1:0]   TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_lat;
  logic [RETRY_W-1:0] r_retry;
  logic [31:0]        r_id_value, r_ts_value;
  logic               r_id_match, r_ts_match, r_error;

  logic w_in_rd, w_accept, w_cap_id, w_cap_ts, w_lat_load;
  logic w_retry_inc, w_fail, w_check, w_start_clr;
  logic w_tmr_clear, w_tmr_en, w_expired;

  sysid_ctrl_timer u_timer (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_en),
    .i_limit   (TMR_LIMIT),
    .o_expired (w_expired)
  );

  assign w_in_rd = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    w_accept    = 1'b0;
    w_cap_id    = 1'b0;
    w_cap_ts    = 1'b0;
    w_lat_load  = 1'b0;
    w_retry_inc = 1'b0;
    w_fail      = 1'b0;
    w_check     = 1'b0;
    w_start_clr = 1'b0;
    w_tmr_clear = 1'b1;
    w_tmr_en    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RD_ID;
      ST_RD_ID, ST_RD_TS: begin
        avm_address = (r_state == ST_RD_TS) ? ADDR_TS : ADDR_ID;
        w_tmr_clear = 1'b0;
        w_tmr_en    = 1'b1;
        if (w_expired) begin
          // Expired cycle doubles as the one-cycle read gap before re-issue.
          w_tmr_clear = 1'b1;
          if (r_retry == RETRY_MAX) begin
            w_fail      = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_retry_inc = 1'b1;
          end
        end else begin
          avm_read = 1'b1;
          if (!avm_waitrequest) begin
            w_accept    = 1'b1;
            w_tmr_clear = 1'b1;
            if (READ_LATENCY == 0) begin
              w_cap_id    = (r_state == ST_RD_ID);
              w_cap_ts    = (r_state == ST_RD_TS);
              w_state_nxt = (r_state == ST_RD_ID) ? ST_RD_TS : ST_CHECK;
            end else begin
              w_lat_load  = 1'b1;
              w_state_nxt = (r_state == ST_RD_ID) ? ST_WT_ID : ST_WT_TS;
            end
          end
        end
      end
      ST_WT_ID, ST_WT_TS: begin
        avm_address = (r_state == ST_WT_TS) ? ADDR_TS : ADDR_ID;
        if (r_lat == 2'd0) begin
          w_cap_id    = (r_state == ST_WT_ID);
          w_cap_ts    = (r_state == ST_WT_TS);
          w_state_nxt = (r_state == ST_WT_ID) ? ST_RD_TS : ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_check     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          w_start_clr = 1'b1;
          w_state_nxt = ST_RD_ID;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_lat      <= '0;
      r_retry    <= '0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_cap_id) r_id_value <= avm_readdata;
      if (w_cap_ts) r_ts_value <= avm_readdata;
      if (w_lat_load)           r_lat <= LAT_LOAD;
      else if (r_lat != 2'd0)   r_lat <= r_lat - 2'd1;
      if (!w_in_rd || w_accept) r_retry <= '0;
      else if (w_retry_inc)     r_retry <= r_retry + 1'b1;
      if (w_start_clr) begin
        r_id_match <= 1'b0;
        r_ts_match <= 1'b0;
        r_error    <= 1'b0;
      end else begin
        if (w_check) begin
          r_id_match <= (r_id_value == EXPECTED_ID);
          r_ts_match <= (r_ts_value == EXPECTED_TIMESTAMP);
        end
        if (w_fail) r_error <= 1'b1;
      end
    end
  end

  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;
  assign id_match        = r_id_match;
  assign ts_match        = r_ts_match;
  assign error           = r_error;
  assign done            = (r_state == ST_DONE);
  assign busy            = (r_state == ST_RD_ID) || (r_state == ST_WT_ID) ||
                           (r_state == ST_RD_TS) || (r_state == ST_WT_TS) ||
                           (r_state == ST_CHECK);

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench: default config, a stuck-waitrequest timeout config and a
// READ_LATENCY=2 config run side by side from a shared clock and reset.
module tb_sysid_check_ctrl;

  localparam logic [31:0] TS_OK  = 32'd1453786952;
  localparam logic [31:0] TS_BAD = 32'd1453786953;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] ts_ret = TS_OK;
  logic        wr_en = 1'b0;
  int          stall_cnt = 0;

  // default DUT
  logic        m_start = 1'b0, m_addr, m_read, m_wait, m_busy, m_done, m_idm, m_tsm, m_err;
  logic [31:0] m_rdata, m_id, m_ts;
  // timeout DUT
  logic        t_start = 1'b0, t_addr, t_read, t_wait, t_busy, t_done, t_idm, t_tsm, t_err;
  logic [31:0] t_rdata, t_id, t_ts;
  // latency DUT
  logic        l_start = 1'b0, l_addr, l_read, l_wait, l_busy, l_done, l_idm, l_tsm, l_err;
  logic [31:0] l_rdata, l_id, l_ts;

  assign m_wait  = wr_en && (stall_cnt < 5);
  assign m_rdata = m_addr ? ts_ret : 32'd0;
  assign t_wait  = 1'b1;
  assign t_rdata = 32'd0;
  assign l_wait  = 1'b0;
  assign l_rdata = l_addr ? ts_ret : 32'd0;

  always @(posedge clock) begin
    if (m_read && m_wait)       stall_cnt <= stall_cnt + 1;
    else if (m_read && !m_wait) stall_cnt <= 0;
  end

  sysid_check_ctrl u_dut (
    .clock(clock), .reset_n(reset_n), .start(m_start),
    .avm_address(m_addr), .avm_read(m_read), .avm_waitrequest(m_wait),
    .avm_readdata(m_rdata), .id_value(m_id), .timestamp_value(m_ts),
    .busy(m_busy), .done(m_done), .id_match(m_idm), .ts_match(m_tsm), .error(m_err)
  );

  sysid_check_ctrl #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) u_to (
    .clock(clock), .reset_n(reset_n), .start(t_start),
    .avm_address(t_addr), .avm_read(t_read), .avm_waitrequest(t_wait),
    .avm_readdata(t_rdata), .id_value(t_id), .timestamp_value(t_ts),
    .busy(t_busy), .done(t_done), .id_match(t_idm), .ts_match(t_tsm), .error(t_err)
  );

  sysid_check_ctrl #(.READ_LATENCY(2)) u_lat (
    .clock(clock), .reset_n(reset_n), .start(l_start),
    .avm_address(l_addr), .avm_read(l_read), .avm_waitrequest(l_wait),
    .avm_readdata(l_rdata), .id_value(l_id), .timestamp_value(l_ts),
    .busy(l_busy), .done(l_done), .id_match(l_idm), .ts_match(l_tsm), .error(l_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] obs_m_rd, obs_m_addr, obs_l_rd, obs_t_rd, obs_t_addr, obs_s_rd, obs_s_addr, obs_s_done;
  logic [31:0] exp_m_rd, exp_m_addr, exp_l_rd, exp_t_rd, exp_s_rd, exp_s_addr, exp_s_done;
  int m_done_edge, l_done_edge, t_done_edge;

  initial begin
    // ---- reset values ----
    #12;
    check("rst_read",   {31'd0, m_read}, 32'd0);
    check("rst_addr",   {31'd0, m_addr}, 32'd0);
    check("rst_status", {27'd0, m_busy, m_done, m_idm, m_tsm, m_err}, 32'd0);
    check("rst_id",     m_id, 32'd0);
    check("rst_ts",     m_ts, 32'd0);
    check("rst_to_read", {31'd0, t_read}, 32'd0);

    // ---- expected models for the post-reset run ----
    exp_m_rd = '0; exp_m_addr = '0; exp_l_rd = '0; exp_t_rd = '0;
    for (int k = 1; k <= 30; k++) begin
      exp_m_rd[k]   = (k <= 2);
      exp_m_addr[k] = (k == 2);
      exp_l_rd[k]   = (k == 1) || (k == 4);
      exp_t_rd[k]   = (k <= 26) && ((k % 9) != 0);
    end

    @(negedge clock);
    reset_n = 1'b1;
    obs_m_rd = '0; obs_m_addr = '0; obs_l_rd = '0; obs_t_rd = '0; obs_t_addr = '0;
    m_done_edge = 0; l_done_edge = 0; t_done_edge = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      obs_m_rd[k]   = m_read;
      obs_m_addr[k] = m_addr;
      obs_l_rd[k]   = l_read;
      obs_t_rd[k]   = t_read;
      obs_t_addr[k] = t_addr;
      if (m_done && m_done_edge == 0) m_done_edge = k;
      if (l_done && l_done_edge == 0) l_done_edge = k;
      if (t_done && t_done_edge == 0) t_done_edge = k;
    end
    check("auto_read_pattern", obs_m_rd, exp_m_rd);
    check("auto_addr_pattern", obs_m_addr, exp_m_addr);
    check("auto_done_edge", m_done_edge, 32'd4);
    check("auto_status", {27'd0, m_busy, m_done, m_idm, m_tsm, m_err}, 32'b01110);
    check("auto_id", m_id, 32'd0);
    check("auto_ts", m_ts, TS_OK);
    check("lat2_done_edge", l_done_edge, 32'd8);
    check("lat2_read_pattern", obs_l_rd, exp_l_rd);
    check("lat2_status", {27'd0, l_busy, l_done, l_idm, l_tsm, l_err}, 32'b01110);
    check("lat2_ts", l_ts, TS_OK);
    check("to_read_bursts", obs_t_rd, exp_t_rd);
    check("to_addr_stable", obs_t_addr, 32'd0);
    check("to_done_edge", t_done_edge, 32'd28);
    check("to_status", {27'd0, t_busy, t_done, t_idm, t_tsm, t_err}, 32'b01001);

    // ---- restart with a wrong timestamp ----
    ts_ret = TS_BAD;
    @(negedge clock);
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    check("restart_status", {27'd0, m_busy, m_done, m_idm, m_tsm, m_err}, 32'b10000);
    check("restart_read", {31'd0, m_read}, 32'd1);
    check("restart_ts_held", m_ts, TS_OK);
    tick(); tick();
    check("bad_ts_not_done", {31'd0, m_done}, 32'd0);
    tick();
    check("bad_ts_status", {27'd0, m_busy, m_done, m_idm, m_tsm, m_err}, 32'b01100);
    check("bad_ts_value", m_ts, TS_BAD);

    // ---- 5-cycle stalls on each access, start pulsed while busy ----
    ts_ret = TS_OK;
    wr_en  = 1'b1;
    exp_s_rd = '0; exp_s_addr = '0; exp_s_done = '0;
    for (int k = 1; k <= 18; k++) begin
      exp_s_rd[k]   = (k <= 12);
      exp_s_addr[k] = (k >= 7) && (k <= 12);
      exp_s_done[k] = (k >= 14);
    end
    obs_s_rd = '0; obs_s_addr = '0; obs_s_done = '0;
    @(negedge clock);
    m_start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      m_start = (k == 3);
      obs_s_rd[k]   = m_read;
      obs_s_addr[k] = m_addr;
      obs_s_done[k] = m_done;
    end
    check("stall_read_pattern", obs_s_rd, exp_s_rd);
    check("stall_addr_pattern", obs_s_addr, exp_s_addr);
    check("stall_done_pattern", obs_s_done, exp_s_done);
    check("stall_status", {27'd0, m_busy, m_done, m_idm, m_tsm, m_err}, 32'b01110);

    // ---- reset while stalled in RD_TS ----
    ts_ret = TS_BAD;
    @(negedge clock);
    m_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      m_start = 1'b0;
    end
    check("pre_rst_in_rdts", {30'd0, m_read, m_addr}, 32'b11);
    check("pre_rst_ts_held", m_ts, TS_OK);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_read", {31'd0, m_read}, 32'd0);
    check("midrst_addr", {31'd0, m_addr}, 32'd0);
    check("midrst_status", {27'd0, m_busy, m_done, m_idm, m_tsm, m_err}, 32'd0);
    check("midrst_ts", m_ts, 32'd0);
    wr_en  = 1'b0;
    ts_ret = TS_OK;
    @(negedge clock);
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("rerun_not_done", {31'd0, m_done}, 32'd0);
    tick();
    check("rerun_status", {27'd0, m_busy, m_done, m_idm, m_tsm, m_err}, 32'b01110);
    check("rerun_ts", m_ts, TS_OK);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
